adc_cap_sequencer: RTL

ADC_CAP_SEQUENCER -- requirements
Module: adc_cap_sequencer

---
 rtl/adc_cap_pkg.sv | 26 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/adc_cap_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/adc_cap_pkg.sv
// Shared definitions for the ADC capture sequencer: FSM state encoding,
// capture counter width and the legal HOLD_CYCLES range.
package adc_cap_pkg;

    localparam int CAP_CNT_W  = 16;
    localparam int HOLD_MIN   = 3;
    localparam int HOLD_MAX   = 15;
    // Wide enough to count up to HOLD_MAX.
    localparam int HOLD_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ARM        = 3'd1,
        ST_PULSE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_DONE  = 3'd4,
        ST_ACK        = 3'd5
    } state_t;

    // True when the hold time is in range and the watchdog limit is a power of two.
    function automatic bit cfg_valid(input int hold, input int timeout);
        return (hold >= HOLD_MIN) && (hold <= HOLD_MAX) &&
               (timeout >= 2) && ((timeout & (timeout - 1)) == 0);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant that starts searching at
// the index after the last advanced grant; index 0 has priority after reset.
module rr_arbiter #(
    parameter int NREQ = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    input  logic            advance_i,
    output logic [NREQ-1:0] gnt_o
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [NREQ-1:0]  w_mask;
    logic [NREQ-1:0]  w_masked;
    logic [NREQ-1:0]  w_sel;
    logic [PTR_W-1:0] w_idx;

    // Requests at or above the pointer get first look.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign w_mask[gi] = (PTR_W'(gi) >= r_ptr);
        end
    endgenerate

    assign w_masked = req_i & w_mask;
    assign w_sel    = (|w_masked) ? w_masked : req_i;
    // Isolate the lowest set bit of the selected vector.
    assign gnt_o    = w_sel & (~w_sel + NREQ'(1));

    // Encode the one-hot grant into an index for the pointer update.
    always_comb begin
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt_o[k]) begin
                w_idx = PTR_W'(k);
            end
        end
    end

    // Move the pointer past the winner whenever the grant is taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else if (advance_i && (|gnt_o)) begin
            r_ptr <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/adc_cap_sequencer.sv
// ADC capture sequencer: arbitrates capture requests, strobes capture_o to all
// channels in lockstep, waits for the channels to go busy and then idle again,
// and acknowledges the granted requester.
// Optional watchdog enabled by defining ADC_CAP_SEQ_TIMEOUT_EN.
module adc_cap_sequencer
    import adc_cap_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int NCH         = 2,
    parameter int HOLD_CYCLES = 4,
    parameter int TIMEOUT     = 65536
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      ack_o,
    output logic                 capture_o,
    input  logic [NCH-1:0]       done_i,
    output logic                 busy_o,
    output logic                 timeout_o,
    input  logic                 clear_i,
    output logic [CAP_CNT_W-1:0] cap_count_o
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

    // Out-of-range configurations leave this marker block in the hierarchy.
    if (!cfg_valid(HOLD_CYCLES, TIMEOUT)) begin : g_cfg_out_of_range
    end

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NREQ-1:0]        r_gnt;
    logic [NREQ-1:0]        w_arb_gnt;
    logic                   w_take;
    logic [HOLD_CNT_W-1:0]  r_hold_cnt;
    logic [CAP_CNT_W-1:0]   r_cap_count;
    logic                   w_all_idle;
    logic                   w_all_busy;
    logic                   w_wd_fire;
    logic                   w_to_ack;

    assign w_all_idle = &done_i;
    assign w_all_busy = ~(|done_i);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_i),
        .advance_i (w_take),
        .gnt_o     (w_arb_gnt)
    );

`ifdef ADC_CAP_SEQ_TIMEOUT_EN
    localparam int             WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_timeout;
    logic            r_to_ack;
    logic            w_in_capture;

    assign w_in_capture = (r_state == ST_PULSE) || (r_state == ST_WAIT_START) ||
                          (r_state == ST_WAIT_DONE);
    assign w_wd_fire    = w_in_capture && (r_wd_cnt == WD_LAST);
    assign timeout_o    = r_timeout;
    assign w_to_ack     = r_to_ack;

    // Watchdog counts cycles since PULSE entry; cleared while arming.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_ARM) begin
            r_wd_cnt <= '0;
        end else if (w_in_capture) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
        end
    end

    // Sticky timeout flag (a new expiry beats a simultaneous clear) and a
    // marker that the coming ACK was forced by the watchdog.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_timeout <= 1'b0;
            r_to_ack  <= 1'b0;
        end else begin
            r_to_ack <= w_wd_fire;
            if (w_wd_fire) begin
                r_timeout <= 1'b1;
            end else if (clear_i) begin
                r_timeout <= 1'b0;
            end
        end
    end
`else
    assign w_wd_fire = 1'b0;
    assign w_to_ack  = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and grant-take strobe.
    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if ((|req_i) && w_all_idle) begin
                    w_take       = 1'b1;
                    w_state_next = ST_ARM;
                end
            end
            ST_ARM:        w_state_next = ST_PULSE;
            ST_PULSE:      if (r_hold_cnt == HOLD_LAST) w_state_next = ST_WAIT_START;
            ST_WAIT_START: if (w_all_busy) w_state_next = ST_WAIT_DONE;
            ST_WAIT_DONE:  if (w_all_idle) w_state_next = ST_ACK;
            ST_ACK:        w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
        if (w_wd_fire) begin
            w_state_next = ST_ACK;
        end
    end

    // Pulse-width counter, running only while in PULSE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold_cnt <= '0;
        end else if (r_state != ST_PULSE) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_CNT_W'(1);
        end
    end

    // Grant is latched at take time and held until the ACK cycle ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gnt <= '0;
        end else if (w_take) begin
            r_gnt <= w_arb_gnt;
        end else if (r_state == ST_ACK) begin
            r_gnt <= '0;
        end
    end

    // Completed-capture counter; clear beats increment, watchdog ACKs don't count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cap_count <= '0;
        end else if (clear_i) begin
            r_cap_count <= '0;
        end else if ((r_state == ST_ACK) && !w_to_ack) begin
            r_cap_count <= r_cap_count + CAP_CNT_W'(1);
        end
    end

    assign gnt_o       = r_gnt;
    assign ack_o       = (r_state == ST_ACK) ? r_gnt : '0;
    assign capture_o   = (r_state == ST_PULSE);
    assign busy_o      = (r_state != ST_IDLE);
    assign cap_count_o = r_cap_count;

endmodule
